radio_timing_seq: RTL and testbench



---
 rtl/radio_timing_seq_pkg.sv | 21 ++
 rtl/radio_timing_seq_if.sv | 38 +++
 rtl/radio_timing_seq_ack_sync.sv | 24 ++
 rtl/radio_timing_seq.sv | 177 +++++++++++++++++
 tb/tb_radio_timing_seq.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/radio_timing_seq_pkg.sv
// Shared state encoding, watchdog length and duration bundle for the radio timing sequencer.
package radio_timing_pkg;

  localparam int ACK_TIMEOUT_CYCLES = 256;
  localparam int DUR_W              = 16;

  typedef enum logic [2:0] {
    IDLE,
    RAMP,
    WAIT_ACK,
    ACTIVE,
    TAIL
  } seq_state_e;

  typedef struct packed {
    logic [DUR_W-1:0] ramp;
    logic [DUR_W-1:0] active;
    logic [DUR_W-1:0] tail;
  } dur_t;

endpackage

// File: rtl/radio_timing_seq_if.sv
// Control/status bundle between a slot scheduler (master) and the radio timing sequencer (slave).
// repeat_count exists only when RADIO_TIMING_SEQ_REPEAT_EN is defined.
interface radio_timing_seq_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             rx_mode;
  logic             abort;
  logic [CNT_W-1:0] ramp_cycles;
  logic [CNT_W-1:0] active_cycles;
  logic [CNT_W-1:0] tail_cycles;
  logic             radio_enable_ack;
`ifdef RADIO_TIMING_SEQ_REPEAT_EN
  logic [7:0]       repeat_count;
`endif
  logic             radioEnableUnsynced;
  logic             radioRxEnUnsynced;
  logic             busy;
  logic             done;
  logic             ack_timeout;

  modport master (
    output start, rx_mode, abort, ramp_cycles, active_cycles, tail_cycles, radio_enable_ack,
`ifdef RADIO_TIMING_SEQ_REPEAT_EN
    output repeat_count,
`endif
    input  radioEnableUnsynced, radioRxEnUnsynced, busy, done, ack_timeout
  );

  modport slave (
    input  start, rx_mode, abort, ramp_cycles, active_cycles, tail_cycles, radio_enable_ack,
`ifdef RADIO_TIMING_SEQ_REPEAT_EN
    input  repeat_count,
`endif
    output radioEnableUnsynced, radioRxEnUnsynced, busy, done, ack_timeout
  );

endinterface

// File: rtl/radio_timing_seq_ack_sync.sv
// STAGES-deep synchroniser for the radio-domain acknowledge; latency STAGES cycles, no backpressure.
module radio_ack_sync #(
  parameter int STAGES = 2
) (
  input  logic ck,
  input  logic arst_n,
  input  logic i_async,
  output logic o_sync
);

  logic [STAGES-1:0] r_chain;

  // Shift form keeps a single-stage build legal.
  always_ff @(posedge ck or negedge arst_n) begin
    if (!arst_n) begin
      r_chain <= '0;
    end else begin
      r_chain <= (r_chain << 1) | STAGES'(i_async);
    end
  end

  assign o_sync = r_chain[STAGES-1];

endmodule

// File: rtl/radio_timing_seq.sv
// Sequences registered radio enable / RX enable levels from start + ramp/active/tail durations; start acts next cycle.
// No backpressure: start while busy (or in the done cycle) is dropped. RADIO_TIMING_SEQ_REPEAT_EN adds repeat_count.
import radio_timing_pkg::*;

module radio_timing_seq #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input logic               ck,
  input logic               arst_n,
  radio_timing_seq_if.slave bus
);

  localparam int WD_W = $clog2(ACK_TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(ACK_TIMEOUT_CYCLES - 1);

  seq_state_e       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [WD_W-1:0]  r_wd, w_wd_nxt;
  dur_t             r_dur, w_dur_nxt;
  logic             r_rx_mode, w_rx_mode_nxt;
  logic             r_en, w_en_nxt;
  logic             r_rx_en, w_rx_en_nxt;
  logic             r_busy;
  logic             r_done, w_done_nxt;
  logic             r_ack_to, w_ack_to_nxt;
  logic             w_ack;
`ifdef RADIO_TIMING_SEQ_REPEAT_EN
  logic [7:0]       r_rep, w_rep_nxt;
`endif

  radio_ack_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .ck      (ck),
    .arst_n  (arst_n),
    .i_async (bus.radio_enable_ack),
    .o_sync  (w_ack)
  );

  always_ff @(posedge ck or negedge arst_n) begin
    if (!arst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_wd_nxt      = r_wd;
    w_dur_nxt     = r_dur;
    w_rx_mode_nxt = r_rx_mode;
    w_en_nxt      = r_en;
    w_rx_en_nxt   = r_rx_en;
    w_done_nxt    = 1'b0;
    w_ack_to_nxt  = r_ack_to;
`ifdef RADIO_TIMING_SEQ_REPEAT_EN
    w_rep_nxt     = r_rep;
`endif
    unique case (r_state)
      IDLE: begin
        // r_done blocks a restart in the very cycle IDLE is re-entered.
        if (bus.start && !bus.abort && !r_done) begin
          w_state_nxt      = RAMP;
          w_en_nxt         = 1'b1;
          w_cnt_nxt        = bus.ramp_cycles;
          w_dur_nxt.ramp   = DUR_W'(bus.ramp_cycles);
          w_dur_nxt.active = DUR_W'(bus.active_cycles);
          w_dur_nxt.tail   = DUR_W'(bus.tail_cycles);
          w_rx_mode_nxt    = bus.rx_mode;
          w_ack_to_nxt     = 1'b0;
`ifdef RADIO_TIMING_SEQ_REPEAT_EN
          w_rep_nxt        = bus.repeat_count;
`endif
        end
      end
      RAMP: begin
        if (bus.abort) begin
          w_state_nxt = TAIL;
          w_cnt_nxt   = CNT_W'(r_dur.tail);
        end else if (r_cnt == '0) begin
          w_state_nxt = WAIT_ACK;
          w_wd_nxt    = '0;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      WAIT_ACK: begin
        if (bus.abort) begin
          w_state_nxt = TAIL;
          w_cnt_nxt   = CNT_W'(r_dur.tail);
        end else if (w_ack) begin
          w_state_nxt = ACTIVE;
          w_cnt_nxt   = CNT_W'(r_dur.active);
          w_rx_en_nxt = r_rx_mode;
        end else if (r_wd == WD_LAST) begin
          w_state_nxt  = TAIL;
          w_cnt_nxt    = CNT_W'(r_dur.tail);
          w_ack_to_nxt = 1'b1;
        end else begin
          w_wd_nxt = r_wd + WD_W'(1);
        end
      end
      ACTIVE: begin
        if (bus.abort || r_cnt == '0) begin
          w_state_nxt = TAIL;
          w_cnt_nxt   = CNT_W'(r_dur.tail);
          w_rx_en_nxt = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      TAIL: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
`ifdef RADIO_TIMING_SEQ_REPEAT_EN
        end else if (r_rep != '0 && !bus.abort) begin
          w_state_nxt = RAMP;
          w_cnt_nxt   = CNT_W'(r_dur.ramp);
          w_rep_nxt   = r_rep - 8'd1;
`endif
        end else begin
          w_state_nxt = IDLE;
          w_en_nxt    = 1'b0;
          w_done_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_en_nxt    = 1'b0;
        w_rx_en_nxt = 1'b0;
      end
    endcase
`ifdef RADIO_TIMING_SEQ_REPEAT_EN
    if (bus.abort && r_state != IDLE) begin
      w_rep_nxt = '0;
    end
`endif
  end

  always_ff @(posedge ck or negedge arst_n) begin
    if (!arst_n) begin
      r_cnt     <= '0;
      r_wd      <= '0;
      r_dur     <= '0;
      r_rx_mode <= 1'b0;
      r_en      <= 1'b0;
      r_rx_en   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ack_to  <= 1'b0;
`ifdef RADIO_TIMING_SEQ_REPEAT_EN
      r_rep     <= '0;
`endif
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_wd      <= w_wd_nxt;
      r_dur     <= w_dur_nxt;
      r_rx_mode <= w_rx_mode_nxt;
      r_en      <= w_en_nxt;
      r_rx_en   <= w_rx_en_nxt;
      r_busy    <= (w_state_nxt != IDLE);
      r_done    <= w_done_nxt;
      r_ack_to  <= w_ack_to_nxt;
`ifdef RADIO_TIMING_SEQ_REPEAT_EN
      r_rep     <= w_rep_nxt;
`endif
    end
  end

  assign bus.radioEnableUnsynced = r_en;
  assign bus.radioRxEnUnsynced   = r_rx_en;
  assign bus.busy                = r_busy;
  assign bus.done                = r_done;
  assign bus.ack_timeout         = r_ack_to;

endmodule

// File: tb/tb_radio_timing_seq.sv
// Self-checking bench for radio_timing_seq: per-cycle output vectors {en,rx,busy,done,ack_timeout}
// are compared with a timeline model built from phase lengths.
module tb_radio_timing_seq;

  localparam int CNT_W    = 16;
  localparam int MAXS     = 600;
  localparam int ACK_WAIT = 256;

  logic ck     = 1'b0;
  logic arst_n = 1'b1;
  always #5 ck = ~ck;

  radio_timing_seq_if #(.CNT_W(CNT_W)) bus();

  radio_timing_seq #(.CNT_W(CNT_W), .SYNC_STAGES(2)) dut (
    .ck     (ck),
    .arst_n (arst_n),
    .bus    (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [4:0] cap   [MAXS];
  logic [4:0] exp_v [MAXS];
`ifdef RADIO_TIMING_SEQ_REPEAT_EN
  logic [7:0] rep_req = 8'd0;
`endif

  function automatic logic [4:0] outs();
    return {bus.radioEnableUnsynced, bus.radioRxEnUnsynced, bus.busy, bus.done, bus.ack_timeout};
  endfunction

  task automatic clear_exp();
    for (int k = 0; k < MAXS; k++) exp_v[k] = '0;
  endtask

  // Timeline model: sample k is taken just after the k-th edge following the start edge.
  task automatic model(input int ramp, input int act, input int tl, input bit rx, input int reps,
                       input bit ack_ok, input int abort_at, input int offset, input int n,
                       output int t_end);
    int  base, a_st, t_st;
    bit  aborted;
    base = offset;
    for (int j = 0; j <= reps; j++) begin
      a_st = base + ramp + 1 + (ack_ok ? 1 : ACK_WAIT);
      t_st = ack_ok ? a_st + act + 1 : a_st;
      aborted = (abort_at >= base) && (abort_at < t_st);
      if (aborted) t_st = abort_at + 1;
      for (int k = base; k < t_st + tl + 1 && k < n; k++) begin
        exp_v[k][4] = 1'b1;
        exp_v[k][2] = 1'b1;
      end
      if (rx && ack_ok)
        for (int k = a_st; k < t_st && k < n; k++) exp_v[k][3] = 1'b1;
      if (!ack_ok)
        for (int k = t_st; k < n; k++) exp_v[k][0] = 1'b1;
      base = t_st + tl + 1;
      if (aborted) break;
    end
    if (base < n) exp_v[base][1] = 1'b1;
    t_end = base;
  endtask

  // Issues start, then records n samples; abort/extra start pulses are placed by sample index.
  task automatic run_seq(input int ramp, input int act, input int tl, input bit rx,
                         input int abort_at, input int s2_lo, input int s2_hi, input int n);
    bus.ramp_cycles   = CNT_W'(ramp);
    bus.active_cycles = CNT_W'(act);
    bus.tail_cycles   = CNT_W'(tl);
    bus.rx_mode       = rx;
    bus.abort         = 1'b0;
    bus.start         = 1'b1;
`ifdef RADIO_TIMING_SEQ_REPEAT_EN
    bus.repeat_count  = rep_req;
`endif
    @(posedge ck); #1;
    bus.start = 1'b0;
    if (s2_lo < 0) begin
      bus.ramp_cycles   = CNT_W'($urandom);
      bus.active_cycles = CNT_W'($urandom);
      bus.tail_cycles   = CNT_W'($urandom);
      bus.rx_mode       = ~rx;
`ifdef RADIO_TIMING_SEQ_REPEAT_EN
      bus.repeat_count  = 8'($urandom);
`endif
    end
    for (int k = 0; k < n; k++) begin
      cap[k]    = outs();
      bus.start = (k >= s2_lo) && (k <= s2_hi);
      bus.abort = (k == abort_at);
      @(posedge ck); #1;
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
  endtask

  task automatic test_reset();
    #1 arst_n = 1'b0;
    #2;
    checks++;
    if (outs() !== 5'b0) begin
      errors++; $display("FAIL reset_async outs=%b expected=%b", outs(), 5'b0);
    end
    @(posedge ck); #1;
    checks++;
    if (outs() !== 5'b0) begin
      errors++; $display("FAIL reset_held outs=%b expected=%b", outs(), 5'b0);
    end
    arst_n = 1'b1;
    repeat (4) @(posedge ck);
    #1;
    checks++;
    if (outs() !== 5'b0) begin
      errors++; $display("FAIL reset_release outs=%b expected=%b", outs(), 5'b0);
    end
  endtask

  task automatic test_basic_rx();
    int t;
    clear_exp();
    model(3, 5, 2, 1'b1, 0, 1'b1, -1, 0, 17, t);
    run_seq(3, 5, 2, 1'b1, -1, -1, -1, 17);
    for (int k = 0; k < 17; k++) begin
      checks++;
      if (cap[k] !== exp_v[k]) begin
        errors++; $display("FAIL basic_rx k=%0d outs=%b expected=%b", k, cap[k], exp_v[k]);
      end
    end
  endtask

  task automatic test_tx();
    int t;
    clear_exp();
    model(3, 5, 2, 1'b0, 0, 1'b1, -1, 0, 17, t);
    run_seq(3, 5, 2, 1'b0, -1, -1, -1, 17);
    for (int k = 0; k < 17; k++) begin
      checks++;
      if (cap[k] !== exp_v[k]) begin
        errors++; $display("FAIL tx k=%0d outs=%b expected=%b", k, cap[k], exp_v[k]);
      end
    end
  endtask

  task automatic test_ack_timeout();
    int t;
    bus.radio_enable_ack = 1'b0;
    repeat (4) @(posedge ck);
    #1;
    clear_exp();
    model(1, 2, 1, 1'b1, 0, 1'b0, -1, 0, 263, t);
    run_seq(1, 2, 1, 1'b1, -1, -1, -1, 263);
    for (int k = 0; k < 263; k++) begin
      checks++;
      if (cap[k] !== exp_v[k]) begin
        errors++; $display("FAIL ack_timeout k=%0d outs=%b expected=%b", k, cap[k], exp_v[k]);
      end
    end
    bus.radio_enable_ack = 1'b1;
    repeat (4) @(posedge ck);
    #1;
    clear_exp();
    model(1, 1, 1, 1'b1, 0, 1'b1, -1, 0, 10, t);
    run_seq(1, 1, 1, 1'b1, -1, -1, -1, 10);
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (cap[k] !== exp_v[k]) begin
        errors++; $display("FAIL timeout_clear k=%0d outs=%b expected=%b", k, cap[k], exp_v[k]);
      end
    end
  endtask

  task automatic test_abort();
    int t;
    clear_exp();
    model(3, 5, 2, 1'b1, 0, 1'b1, 6, 0, 14, t);
    run_seq(3, 5, 2, 1'b1, 6, -1, -1, 14);
    for (int k = 0; k < 14; k++) begin
      checks++;
      if (cap[k] !== exp_v[k]) begin
        errors++; $display("FAIL abort_active k=%0d outs=%b expected=%b", k, cap[k], exp_v[k]);
      end
    end
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(posedge ck); #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (outs() !== 5'b0) begin
        errors++; $display("FAIL abort_idle k=%0d outs=%b expected=%b", k, outs(), 5'b0);
      end
      @(posedge ck); #1;
    end
  endtask

  task automatic test_back_to_back();
    int t1, t2;
    clear_exp();
    model(0, 0, 0, 1'b1, 0, 1'b1, -1, 0, 13, t1);
    model(0, 0, 0, 1'b1, 0, 1'b1, -1, t1 + 2, 13, t2);
    run_seq(0, 0, 0, 1'b1, -1, 4, 5, 13);
    for (int k = 0; k < 13; k++) begin
      checks++;
      if (cap[k] !== exp_v[k]) begin
        errors++; $display("FAIL back_to_back k=%0d outs=%b expected=%b", k, cap[k], exp_v[k]);
      end
    end
  endtask

  task automatic test_random();
    int t, r, a, tl, ab;
    bit rx;
    for (int it = 0; it < 10; it++) begin
      r  = $urandom_range(0, 5);
      a  = $urandom_range(0, 5);
      tl = $urandom_range(0, 5);
      rx = 1'($urandom_range(0, 1));
      ab = ($urandom_range(0, 2) == 0) ? -1 : $urandom_range(0, 19);
      clear_exp();
      model(r, a, tl, rx, 0, 1'b1, ab, 0, 22, t);
      run_seq(r, a, tl, rx, ab, -1, -1, 22);
      for (int k = 0; k < 22; k++) begin
        checks++;
        if (cap[k] !== exp_v[k]) begin
          errors++;
          $display("FAIL random it=%0d r=%0d a=%0d t=%0d rx=%0d ab=%0d k=%0d outs=%b expected=%b",
                   it, r, a, tl, rx, ab, k, cap[k], exp_v[k]);
        end
      end
    end
  endtask

`ifdef RADIO_TIMING_SEQ_REPEAT_EN
  task automatic test_repeat();
    int t;
    rep_req = 8'd2;
    clear_exp();
    model(1, 1, 1, 1'b1, 2, 1'b1, -1, 0, 24, t);
    run_seq(1, 1, 1, 1'b1, -1, -1, -1, 24);
    rep_req = 8'd0;
    for (int k = 0; k < 24; k++) begin
      checks++;
      if (cap[k] !== exp_v[k]) begin
        errors++; $display("FAIL repeat k=%0d outs=%b expected=%b", k, cap[k], exp_v[k]);
      end
    end
  endtask
`endif

  task automatic test_reset_mid_active();
    bus.ramp_cycles   = CNT_W'(3);
    bus.active_cycles = CNT_W'(5);
    bus.tail_cycles   = CNT_W'(2);
    bus.rx_mode       = 1'b1;
`ifdef RADIO_TIMING_SEQ_REPEAT_EN
    bus.repeat_count  = 8'd0;
`endif
    bus.start = 1'b1;
    @(posedge ck); #1;
    bus.start = 1'b0;
    repeat (6) @(posedge ck);
    #1;
    checks++;
    if (outs() !== 5'b11100) begin
      errors++; $display("FAIL mid_active_pre outs=%b expected=%b", outs(), 5'b11100);
    end
    #2 arst_n = 1'b0;
    #1;
    checks++;
    if (outs() !== 5'b0) begin
      errors++; $display("FAIL reset_mid_active outs=%b expected=%b", outs(), 5'b0);
    end
    @(posedge ck); #1;
    arst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge ck); #1;
      checks++;
      if (outs() !== 5'b0) begin
        errors++; $display("FAIL post_reset_quiet k=%0d outs=%b expected=%b", k, outs(), 5'b0);
      end
    end
  endtask

  initial begin
    bus.start            = 1'b0;
    bus.abort            = 1'b0;
    bus.rx_mode          = 1'b0;
    bus.ramp_cycles      = '0;
    bus.active_cycles    = '0;
    bus.tail_cycles      = '0;
    bus.radio_enable_ack = 1'b1;
`ifdef RADIO_TIMING_SEQ_REPEAT_EN
    bus.repeat_count     = 8'd0;
`endif
    test_reset();
    test_basic_rx();
    test_tx();
    test_ack_timeout();
    test_abort();
    test_back_to_back();
    test_random();
`ifdef RADIO_TIMING_SEQ_REPEAT_EN
    test_repeat();
`endif
    test_reset_mid_active();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
